lsu_sbuf: RTL and testbench

- Parametrised load/store unit for the execute stage, replacing the single-outstanding mem path.
- Adds a posted store buffer of configurable depth, misalignment faulting and fence draining.
- Sits between execute's operand/funct3 decode and the shared data-bus handshake (mem_valid/mem_ready/mem_addr/mem_rdata/mem_wdata/mem_wstrb).
- Execute holds a request stable and stalls until req_done.

---
 rtl/lsu_sbuf_pkg.sv | 31 +++
 rtl/lsu_sbuf_fifo.sv | 69 ++++++
 rtl/lsu_sbuf.sv | 114 +++++++++++
 tb/tb_lsu_sbuf.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_sbuf_pkg.sv
// lsu_sbuf_pkg: shared funct3 size encodings, bus FSM states and lane/strobe helpers.
//   LSU_BYTE/HALF/WORD : funct3[1:0] access size, funct3[LSU_UNSIGNED] zero-extends loads
//   BUS_IDLE/LOAD/STORE: data-bus FSM states
//   lsu_lane/lsu_strb/lsu_misaligned: byte lane, strobe mask and alignment fault for a size/offset
package lsu_sbuf_pkg;
    localparam logic [1:0] LSU_BYTE = 2'd0;
    localparam logic [1:0] LSU_HALF = 2'd1;
    localparam logic [1:0] LSU_WORD = 2'd2;
    localparam int LSU_UNSIGNED = 2;

    localparam logic [1:0] BUS_IDLE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    // Misaligned offsets are truncated down to the access's natural boundary.
    function automatic logic [2:0] lsu_lane(input logic [1:0] size, input logic [2:0] off);
        return size == LSU_BYTE ? off :
               size == LSU_HALF ? {off[2:1], 1'b0} :
               size == LSU_WORD ? {off[2], 2'b00} : 3'b000;
    endfunction

    function automatic logic [7:0] lsu_strb(input logic [1:0] size, input logic [2:0] off);
        return (size == LSU_BYTE ? 8'h01 : size == LSU_HALF ? 8'h03 :
                size == LSU_WORD ? 8'h0F : 8'hFF) << lsu_lane(size, off);
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
        return (size == LSU_HALF && off[0]) || (size == LSU_WORD && off[1:0] != 2'b00) ||
               (size == 2'd3 && off != 3'b000);
    endfunction
endpackage

// File: rtl/lsu_sbuf_fifo.sv
// lsu_sbuf_fifo: circular store buffer of {waddr, wdata, wstrb} entries.
//   push/push_*    : enqueue at tail      pop/head_*  : dequeue / view oldest entry
//   full/empty/count: occupancy           match_addr/match: any valid entry holds this word address
module lsu_sbuf_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_addr,
    input  logic [XLEN-1:0]            push_data,
    input  logic [XLEN/8-1:0]          push_strb,
    output logic [XLEN-1:0]            head_addr,
    output logic [XLEN-1:0]            head_data,
    output logic [XLEN/8-1:0]          head_strb,
    input  logic [XLEN-1:0]            match_addr,
    output logic                       match,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [XLEN/8-1:0] strb_q [DEPTH];
    logic [DEPTH-1:0]  valid, hit;
    logic [PW-1:0]     head, tail, head_n, tail_n;

    assign head_n = head == PW'(DEPTH - 1) ? '0 : head + 1'b1;
    assign tail_n = tail == PW'(DEPTH - 1) ? '0 : tail + 1'b1;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign head_strb = strb_q[head];

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = valid[i] && addr_q[i] == match_addr;
    end
    assign match = |hit;

    // On a full buffer head==tail, so the push's set must land after the pop's clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) head <= head_n;
            if (push) tail <= tail_n;
            count <= count + CW'(push) - CW'(pop);
            if (pop) valid[head] <= 1'b0;
            if (push) valid[tail] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
            strb_q[tail] <= push_strb;
        end
    end
endmodule

// File: rtl/lsu_sbuf.sv
// lsu_sbuf: execute-stage load/store unit with posted store buffer, alignment faults and fence drain.
//   flush/req_load/req_store/req_fence/funct3/base/offset/wval: request from execute, held until req_done
//   req_done/result/misaligned: retirement, formatted load data, fault pulse
//   sb_count: store buffer occupancy
//   mem_*: shared data-bus handshake (registered request, held until mem_ready)
module lsu_sbuf
    import lsu_sbuf_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SB_DEPTH    = 4,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic                        req_load,
    input  logic                        req_store,
    input  logic                        req_fence,
    input  logic [2:0]                  funct3,
    input  logic [XLEN-1:0]             base,
    input  logic [XLEN-1:0]             offset,
    input  logic [XLEN-1:0]             wval,
    output logic                        req_done,
    output logic [XLEN-1:0]             result,
    output logic                        misaligned,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [XLEN-1:0]             mem_addr,
    input  logic [XLEN-1:0]             mem_rdata,
    output logic [XLEN-1:0]             mem_wdata,
    output logic [XLEN/8-1:0]           mem_wstrb
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    logic [1:0]      state, size;
    logic [2:0]      off, lane;
    logic [XLEN-1:0] addr, waddr, sdata, rshift, hmask, fmt;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] head_addr, head_data;
    logic [NB-1:0]   head_strb;
    logic            sbit, mis, push, pop, full, empty, match;
    logic            ld_issue, ld_done, ld_live, fence_done;

    assign addr  = base + offset;
    assign waddr = addr & ~XLEN'(NB - 1);
    assign off   = 3'(addr[LW-1:0]);
    assign size  = funct3[1:0];
    assign lane  = lsu_lane(size, off);
    assign strb  = NB'(lsu_strb(size, off));
    assign sdata = wval << {lane, 3'b000};

    // Load formatting: shift the addressed lane down, then sign/zero fill above the access size.
    assign rshift = mem_rdata >> {lane, 3'b000};
    assign hmask  = size == LSU_BYTE ? {XLEN{1'b1}} << 8 :
                    size == LSU_HALF ? {XLEN{1'b1}} << 16 :
                    size == LSU_WORD ? {XLEN{1'b1}} << 32 : '0;
    assign sbit   = size == LSU_BYTE ? rshift[7] : size == LSU_HALF ? rshift[15] :
                    size == LSU_WORD ? rshift[31] : rshift[XLEN-1];
    assign fmt    = (rshift & ~hmask) | (sbit && !funct3[LSU_UNSIGNED] ? hmask : '0);

    assign mis = ALIGN_CHECK != 0 && (req_load || req_store) && !flush && lsu_misaligned(size, off);
    assign pop = state == BUS_STORE && mem_ready;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the store.
    assign push = req_store && !flush && !mis && (!full || pop);
    // Loads never forward: any buffered store to the same word must reach the bus first.
    assign ld_issue   = state == BUS_IDLE && req_load && !flush && !mis && !match;
    // ld_live ties bus completion to the load that issued it; a flushed load's data is dropped.
    assign ld_done    = state == BUS_LOAD && mem_ready && ld_live && req_load && !flush;
    assign fence_done = req_fence && !flush && empty && state == BUS_IDLE;
    assign req_done   = push || ld_done || fence_done || mis;
    assign misaligned = mis;
    assign result     = ld_done ? fmt : '0;

    lsu_sbuf_fifo #(.XLEN(XLEN), .DEPTH(SB_DEPTH)) u_fifo (
        .clk(clk), .rstn(rstn), .push(push), .pop(pop),
        .push_addr(waddr), .push_data(sdata), .push_strb(strb),
        .head_addr(head_addr), .head_data(head_data), .head_strb(head_strb),
        .match_addr(waddr), .match(match), .full(full), .empty(empty), .count(sb_count)
    );

    // Every transaction returns through IDLE, which leaves mem_valid low for a cycle between them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= BUS_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            ld_live   <= 1'b0;
        end else begin
            if (state == BUS_IDLE) begin
                if (ld_issue) begin
                    state     <= BUS_LOAD;
                    mem_valid <= 1'b1;
                    mem_addr  <= waddr;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                end else if (!empty) begin
                    state     <= BUS_STORE;
                    mem_valid <= 1'b1;
                    mem_addr  <= head_addr;
                    mem_wdata <= head_data;
                    mem_wstrb <= head_strb;
                end
            end else if (mem_ready) begin
                state     <= BUS_IDLE;
                mem_valid <= 1'b0;
            end
            ld_live <= ld_issue || (ld_live && !flush && !(state == BUS_LOAD && mem_ready));
        end
    end
endmodule

// File: tb/tb_lsu_sbuf.sv
// tb_lsu_sbuf: directed table-driven bench for lsu_sbuf plus multi-cycle corner sequences.
module tb_lsu_sbuf;
    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic        req_load = 1'b0, req_store = 1'b0, req_fence = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] base = '0, offset = '0, wval = '0;
    logic        req_done, misaligned, mem_valid;
    logic [31:0] result, mem_addr, mem_wdata;
    logic [2:0]  sb_count;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0, n_fail = 0;

    lsu_sbuf #(.XLEN(32), .SB_DEPTH(4), .ALIGN_CHECK(1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .req_load(req_load), .req_store(req_store),
        .req_fence(req_fence), .funct3(funct3), .base(base), .offset(offset), .wval(wval),
        .req_done(req_done), .result(result), .misaligned(misaligned), .sb_count(sb_count),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wval;
        logic        mis;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic [3:0]  estrb;
        logic [31:0] rdata;
        logic [31:0] eres;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_load = 1'b0; req_store = 1'b0; req_fence = 1'b0; flush = 1'b0;
    endtask

    task automatic put(input logic ld, input logic st, input logic fe, input logic [2:0] f,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] w);
        req_load = ld; req_store = st; req_fence = fe; funct3 = f; base = b; offset = o; wval = w;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!mem_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(mem_valid), 32'd1);
    endtask

    task automatic do_load(input string nm, input logic [2:0] f, input logic [31:0] b, input logic [31:0] o,
                           input logic [31:0] rd, input logic [31:0] eaddr, input logic [31:0] eres);
        put(1'b1, 1'b0, 1'b0, f, b, o, 32'd0);
        @(negedge clk);
        chk({nm, "_early"}, 32'(req_done), 32'd0);
        wait_valid({nm, "_valid"});
        chk({nm, "_addr"}, mem_addr, eaddr);
        chk({nm, "_rstrb"}, 32'(mem_wstrb), 32'd0);
        step();
        mem_rdata = rd; mem_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_done"}, 32'(req_done), 32'd1);
        chk({nm, "_result"}, result, eres);
        step();
        idle(); mem_ready = 1'b0;
    endtask

    task automatic do_store(input string nm, input logic [2:0] f, input logic [31:0] b, input logic [31:0] o,
                            input logic [31:0] w, input logic [31:0] eaddr, input logic [31:0] edata,
                            input logic [3:0] estrb);
        put(1'b0, 1'b1, 1'b0, f, b, o, w);
        @(negedge clk);
        chk({nm, "_done"}, 32'(req_done), 32'd1);
        chk({nm, "_mis"}, 32'(misaligned), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk({nm, "_cnt1"}, 32'(sb_count), 32'd1);
        wait_valid({nm, "_valid"});
        chk({nm, "_addr"}, mem_addr, eaddr);
        chk({nm, "_wdata"}, mem_wdata, edata);
        chk({nm, "_wstrb"}, 32'(mem_wstrb), 32'(estrb));
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_cnt0"}, 32'(sb_count), 32'd0);
        chk({nm, "_idle"}, 32'(mem_valid), 32'd0);
        step();
    endtask

    task automatic do_mis(input string nm, input logic ld, input logic [2:0] f,
                          input logic [31:0] b, input logic [31:0] o);
        put(ld, !ld, 1'b0, f, b, o, 32'h1234_5678);
        @(negedge clk);
        chk({nm, "_done"}, 32'(req_done), 32'd1);
        chk({nm, "_mis"}, 32'(misaligned), 32'd1);
        chk({nm, "_nobus"}, 32'(mem_valid), 32'd0);
        step();
        idle();
        @(negedge clk);
        chk({nm, "_nobus2"}, 32'(mem_valid), 32'd0);
        chk({nm, "_cnt"}, 32'(sb_count), 32'd0);
        step();
    endtask

    task automatic drain(input string nm);
        int k = 0;
        mem_ready = 1'b1;
        @(negedge clk);
        while ((sb_count != 0 || mem_valid) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_drained"}, 32'(sb_count), 32'd0);
        step();
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h1000, 32'd3, 32'hA5, 1'b0, 32'h1000, 32'hA500_0000, 4'b1000, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h1000, 32'd2, 32'h1234, 1'b0, 32'h1000, 32'h1234_0000, 4'b1100, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h1000, 32'd0, 32'hBEEF, 1'b0, 32'h1000, 32'h0000_BEEF, 4'b0011, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h2000, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b0, 32'h1FFC, 32'hCAFE_F00D, 4'b1111, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h1000, 32'd1, 32'h77, 1'b0, 32'h1000, 32'h0000_7700, 4'b0010, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h3000, 32'd2, 32'd0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h3000, 32'd1, 32'd0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h3000, 32'd2, 32'd0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h3000, 32'd3, 32'd0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h4000, 32'd0, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h89AB_CDEF, 32'h89AB_CDEF});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h4000, 32'd1, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h1234_8000, 32'hFFFF_FF80});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h4000, 32'd1, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h1234_8000, 32'h0000_0080});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h4000, 32'd2, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h8001_0000, 32'h0000_8001});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h4000, 32'd2, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h8001_0000, 32'hFFFF_8001});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h4000, 32'd3, 32'd0, 1'b0, 32'h4000, 32'd0, 4'b0000, 32'h7F00_0000, 32'h0000_007F});

        #12;
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        foreach (vecs[i]) begin
            if (vecs[i].mis)
                do_mis($sformatf("v%0d", i), vecs[i].ld, vecs[i].f3, vecs[i].base, vecs[i].off);
            else if (vecs[i].ld)
                do_load($sformatf("v%0d", i), vecs[i].f3, vecs[i].base, vecs[i].off,
                        vecs[i].rdata, vecs[i].eaddr, vecs[i].eres);
            else
                do_store($sformatf("v%0d", i), vecs[i].f3, vecs[i].base, vecs[i].off,
                         vecs[i].wval, vecs[i].eaddr, vecs[i].edata, vecs[i].estrb);
        end

        // Fill the buffer with the bus stalled; the fifth store waits for a drain.
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 1'b1, 1'b0, 3'b010, 32'h7000 + 32'(4 * i), 32'd0, 32'(i + 1));
            @(negedge clk);
            chk($sformatf("fill%0d_done", i), 32'(req_done), 32'd1);
            step();
        end
        idle();
        @(negedge clk);
        chk("fill_count", 32'(sb_count), 32'd4);
        chk("fill_busaddr", mem_addr, 32'h7000);
        chk("fill_busdata", mem_wdata, 32'd1);
        put(1'b0, 1'b1, 1'b0, 3'b010, 32'h7010, 32'd0, 32'd5);
        @(negedge clk);
        chk("full_stall", 32'(req_done), 32'd0);
        step();
        @(negedge clk);
        chk("full_stall2", 32'(req_done), 32'd0);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("full_accept", 32'(req_done), 32'd1);
        step();
        mem_ready = 1'b0;
        idle();
        @(negedge clk);
        chk("full_count", 32'(sb_count), 32'd4);
        drain("full");

        // Load to a word still in the buffer waits for that store to drain.
        put(1'b0, 1'b1, 1'b0, 3'b010, 32'h2000, 32'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("raw_st_done", 32'(req_done), 32'd1);
        step();
        idle();
        wait_valid("raw_st_valid");
        step();
        put(1'b1, 1'b0, 1'b0, 3'b001, 32'h2000, 32'd2, 32'd0);
        @(negedge clk);
        chk("raw_wait", 32'(req_done), 32'd0);
        chk("raw_busaddr", mem_addr, 32'h2000);
        chk("raw_busstrb", 32'(mem_wstrb), 32'hF);
        step();
        @(negedge clk);
        chk("raw_wait2", 32'(req_done), 32'd0);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("raw_wait3", 32'(req_done), 32'd0);
        step();
        mem_ready = 1'b0;
        wait_valid("raw_ld_valid");
        chk("raw_ld_addr", mem_addr, 32'h2000);
        chk("raw_ld_strb", 32'(mem_wstrb), 32'd0);
        step();
        mem_rdata = 32'hDEAD_BEEF; mem_ready = 1'b1;
        @(negedge clk);
        chk("raw_lh_done", 32'(req_done), 32'd1);
        chk("raw_lh_result", result, 32'hFFFF_DEAD);
        step();
        mem_ready = 1'b0; idle();
        do_load("raw_lhu", 3'b101, 32'h2000, 32'd2, 32'hDEAD_BEEF, 32'h2000, 32'h0000_DEAD);

        // Flush an outstanding load; it still completes on the bus, then two stores drain.
        put(1'b1, 1'b0, 1'b0, 3'b010, 32'h6000, 32'd0, 32'd0);
        @(negedge clk);
        wait_valid("fl_valid");
        chk("fl_addr", mem_addr, 32'h6000);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_nodone", 32'(req_done), 32'd0);
        step();
        flush = 1'b0;
        put(1'b0, 1'b1, 1'b0, 3'b010, 32'h6100, 32'd0, 32'h11);
        @(negedge clk);
        chk("fl_st1", 32'(req_done), 32'd1);
        step();
        put(1'b0, 1'b1, 1'b0, 3'b010, 32'h6104, 32'd0, 32'h22);
        @(negedge clk);
        chk("fl_st2", 32'(req_done), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("fl_count", 32'(sb_count), 32'd2);
        chk("fl_held", 32'(mem_valid), 32'd1);
        chk("fl_held_addr", mem_addr, 32'h6000);
        step();
        mem_rdata = 32'h5555_5555; mem_ready = 1'b1;
        @(negedge clk);
        chk("fl_discard", 32'(req_done), 32'd0);
        step();
        mem_ready = 1'b0;
        wait_valid("fl_d1_valid");
        chk("fl_d1_addr", mem_addr, 32'h6100);
        chk("fl_d1_data", mem_wdata, 32'h11);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        wait_valid("fl_d2_valid");
        chk("fl_d2_addr", mem_addr, 32'h6104);
        chk("fl_d2_data", mem_wdata, 32'h22);
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("fl_count0", 32'(sb_count), 32'd0);
        step();

        // Fence waits for the buffer to drain.
        put(1'b0, 1'b1, 1'b0, 3'b010, 32'h6200, 32'd0, 32'h33);
        @(negedge clk);
        step();
        put(1'b0, 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("fence_wait", 32'(req_done), 32'd0);
        mem_ready = 1'b1;
        begin
            int k = 0;
            while (!req_done && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("fence_done", 32'(req_done), 32'd1);
        chk("fence_count", 32'(sb_count), 32'd0);
        step();
        idle(); mem_ready = 1'b0;
        step();

        // Asynchronous reset in the middle of a store with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            put(1'b0, 1'b1, 1'b0, 3'b010, 32'h8000 + 32'(4 * i), 32'd0, 32'(i));
            step();
        end
        idle();
        @(negedge clk);
        chk("ar_count3", 32'(sb_count), 32'd3);
        chk("ar_busy", 32'(mem_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid0", 32'(mem_valid), 32'd0);
        chk("ar_count0", 32'(sb_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        put(1'b0, 1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("ar_fence", 32'(req_done), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("ar_quiet", 32'(mem_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
